iqueue_fetch: RTL and testbench

//  Producer (write) end of the instruction queue. Walks the PC and issues in-order

---
 rtl/iqueue_fetch.sv | 86 ++++++++
 tb/tb_iqueue_fetch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iqueue_fetch.sv
// Fetch front end: walks the PC, reads instruction memory in order and pushes
// {pc, instr} pairs into the instruction queue, restarting cleanly on redirect.
module iqueue_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_read,
  output logic [15:0] imem_address,
  input  logic        imem_resp,
  input  logic [15:0] imem_rdata,
  input  logic        iq_full,
  output logic        iq_load,
  output logic [15:0] iq_pc,
  output logic [15:0] iq_instr
);

  localparam logic [1:0] S_REQ     = 2'd0;
  localparam logic [1:0] S_PUSH    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_pc;
  logic [15:0] r_hold_pc;
  logic [15:0] r_hold_instr;
  logic [15:0] w_redirect_pc;

  assign w_redirect_pc = redirect_pc & 16'hFFFE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC & 16'hFFFE;
      r_hold_pc    <= 16'h0000;
      r_hold_instr <= 16'h0000;
    end else begin
      case (r_state)
        S_REQ: begin
          if (redirect) begin
            r_pc <= w_redirect_pc;
            // The old read is still in flight unless it completes right now;
            // park its address so it stays on the bus until the response drains.
            if (!imem_resp) begin
              r_hold_pc <= r_pc;
              r_state   <= S_DISCARD;
            end
          end else if (imem_resp) begin
            r_hold_pc    <= r_pc;
            r_hold_instr <= imem_rdata;
            r_pc         <= r_pc + 16'd2;
            r_state      <= S_PUSH;
          end
        end
        S_DISCARD: begin
          if (redirect) begin
            r_pc <= w_redirect_pc;
          end
          if (imem_resp) begin
            r_state <= S_REQ;
          end
        end
        S_PUSH: begin
          if (redirect) begin
            r_pc    <= w_redirect_pc;
            r_state <= S_REQ;
          end else if (!iq_full) begin
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state <= S_REQ;
        end
      endcase
    end
  end

  // Reset gates the request strobes so they drop without waiting for a clock.
  assign imem_read    = !reset && ((r_state == S_REQ) || (r_state == S_DISCARD));
  assign imem_address = (r_state == S_DISCARD) ? r_hold_pc : r_pc;
  assign iq_load      = !reset && (r_state == S_PUSH) && !redirect;
  assign iq_pc        = r_hold_pc;
  assign iq_instr     = r_hold_instr;

endmodule

// File: tb/tb_iqueue_fetch.sv
// Bench for iqueue_fetch: directed vector table, a wrap/async-reset sequence on a
// second instance, then random traffic checked against an in-order fetch stream model.
module tb_iqueue_fetch;

  typedef struct {
    logic        redir;
    logic [15:0] rpc;
    logic        resp;
    logic [15:0] rdata;
    logic        full;
    logic        expRead;
    logic [15:0] expAddr;
    logic        expLoad;
    logic [15:0] expPc;
    logic [15:0] expInstr;
  } vec_t;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        imemRead;
  logic [15:0] imemAddress;
  logic        imemResp;
  logic [15:0] imemRdata;
  logic        iqFull;
  logic        iqLoad;
  logic [15:0] iqPc;
  logic [15:0] iqInstr;

  logic        memAuto;
  logic        manResp;
  logic [15:0] manRdata;
  logic        memResp;
  logic [15:0] memRdata;
  logic        memBusy;
  logic [1:0]  memCnt;
  logic [15:0] memAddr;

  logic        reset2;
  logic        redirect2;
  logic        resp2;
  logic [15:0] rdata2;
  logic        full2;
  logic        read2;
  logic [15:0] addr2;
  logic        load2;
  logic [15:0] pc2;
  logic [15:0] instr2;

  int          checks;
  int          errors;
  vec_t        vecs[$];

  assign imemResp  = memAuto ? memResp : manResp;
  assign imemRdata = memAuto ? memRdata : manRdata;

  iqueue_fetch #(.RESET_PC(16'h0000)) u_dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirectPc),
    .imem_read(imemRead), .imem_address(imemAddress), .imem_resp(imemResp),
    .imem_rdata(imemRdata), .iq_full(iqFull), .iq_load(iqLoad), .iq_pc(iqPc),
    .iq_instr(iqInstr)
  );

  // Odd reset PC checks that bit 0 is forced low and that PC+2 wraps.
  iqueue_fetch #(.RESET_PC(16'hFFFF)) u_dut2 (
    .clk(clk), .reset(reset2), .redirect(redirect2), .redirect_pc(16'h0000),
    .imem_read(read2), .imem_address(addr2), .imem_resp(resp2),
    .imem_rdata(rdata2), .iq_full(full2), .iq_load(load2), .iq_pc(pc2),
    .iq_instr(instr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] instrOf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  // Memory model: one outstanding read, random latency 1..3, data derived from address.
  always @(posedge clk or posedge reset) begin
    int lat;
    if (reset) begin
      memBusy  <= 1'b0;
      memResp  <= 1'b0;
      memCnt   <= 2'd0;
      memAddr  <= 16'h0000;
      memRdata <= 16'h0000;
    end else begin
      memResp <= 1'b0;
      if (memBusy) begin
        if (memCnt == 2'd1) begin
          memResp  <= 1'b1;
          memRdata <= instrOf(memAddr);
          memBusy  <= 1'b0;
        end else begin
          memCnt <= memCnt - 2'd1;
        end
      end else if (!memResp && imemRead) begin
        lat = $urandom_range(1, 3);
        memAddr <= imemAddress;
        if (lat == 1) begin
          memResp  <= 1'b1;
          memRdata <= instrOf(imemAddress);
        end else begin
          memBusy <= 1'b1;
          memCnt  <= 2'(lat - 1);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic addVec(input logic redir, input logic [15:0] rpc, input logic resp,
                        input logic [15:0] rdata, input logic full, input logic eRead,
                        input logic [15:0] eAddr, input logic eLoad,
                        input logic [15:0] ePc, input logic [15:0] eInstr);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.resp = resp; v.rdata = rdata; v.full = full;
    v.expRead = eRead; v.expAddr = eAddr; v.expLoad = eLoad;
    v.expPc = ePc; v.expInstr = eInstr;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    redirect   = v.redir;
    redirectPc = v.rpc;
    manResp    = v.resp;
    manRdata   = v.rdata;
    iqFull     = v.full;
  endtask

  initial begin
    int   pushes;
    logic [15:0] expPc;
    logic capture;
    logic accept;

    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    reset2    = 1'b1;
    memAuto   = 1'b0;
    redirect  = 1'b0;
    redirectPc = 16'h0000;
    manResp   = 1'b0;
    manRdata  = 16'h0000;
    iqFull    = 1'b0;
    redirect2 = 1'b0;
    resp2     = 1'b0;
    rdata2    = 16'h0000;
    full2     = 1'b0;

    // Streaming, full back-pressure, redirect with read outstanding,
    // redirect on response, redirect while stalled in push.
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 1, 16'h1111, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0002, 1, 16'h0000, 16'h1111);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 1, 16'h2222, 0, 1, 16'h0002, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0004, 1, 16'h0002, 16'h2222);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0004, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 1, 16'h3333, 0, 1, 16'h0004, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0006, 1, 16'h0004, 16'h3333);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0006, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 1, 16'h4444, 0, 1, 16'h0006, 0, 16'h0000, 16'h0000);
    for (int k = 0; k < 5; k++)
      addVec(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h0008, 1, 16'h0006, 16'h4444);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h0008, 1, 16'h0006, 16'h4444);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0008, 0, 16'h0000, 16'h0000);
    addVec(1, 16'h3001, 0, 16'h0000, 0, 1, 16'h0008, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h0008, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 1, 16'hDEAD, 0, 1, 16'h0008, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h3000, 0, 16'h0000, 16'h0000);
    addVec(1, 16'h4005, 1, 16'hBEEF, 0, 1, 16'h3000, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h4004, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 1, 16'h5555, 0, 1, 16'h4004, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 1, 0, 16'h4006, 1, 16'h4004, 16'h5555);
    addVec(1, 16'h7FF0, 0, 16'h0000, 1, 0, 16'h4006, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h7FF0, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 1, 16'h6666, 0, 1, 16'h7FF0, 0, 16'h0000, 16'h0000);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 0, 16'h7FF2, 1, 16'h7FF0, 16'h6666);
    addVec(0, 16'h0000, 0, 16'h0000, 0, 1, 16'h7FF2, 0, 16'h0000, 16'h0000);

    #1;
    checkOutput("reset imem_read", 16'(imemRead), 16'h0000);
    checkOutput("reset iq_load", 16'(iqLoad), 16'h0000);
    checkOutput("reset imem_address", imemAddress, 16'h0000);
    checkOutput("reset2 imem_address", addr2, 16'hFFFE);
    checkOutput("reset2 imem_read", 16'(read2), 16'h0000);

    @(negedge clk);
    reset = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d imem_read", i), 16'(imemRead), 16'(vecs[i].expRead));
      checkOutput($sformatf("row%0d imem_address", i), imemAddress, vecs[i].expAddr);
      checkOutput($sformatf("row%0d iq_load", i), 16'(iqLoad), 16'(vecs[i].expLoad));
      if (vecs[i].expLoad) begin
        checkOutput($sformatf("row%0d iq_pc", i), iqPc, vecs[i].expPc);
        checkOutput($sformatf("row%0d iq_instr", i), iqInstr, vecs[i].expInstr);
      end
    end

    // Second instance: start at FFFE, wrap to 0000, then async reset mid-push.
    @(negedge clk);
    reset2 = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("wrap first addr", addr2, 16'hFFFE);
    checkOutput("wrap first read", 16'(read2), 16'h0001);
    @(negedge clk);
    resp2 = 1'b1; rdata2 = 16'hABCD;
    @(negedge clk);
    resp2 = 1'b0;
    #1;
    checkOutput("wrap push load", 16'(load2), 16'h0001);
    checkOutput("wrap push pc", pc2, 16'hFFFE);
    checkOutput("wrap push instr", instr2, 16'hABCD);
    @(negedge clk);
    #1;
    checkOutput("wrap next addr", addr2, 16'h0000);
    checkOutput("wrap next read", 16'(read2), 16'h0001);
    @(negedge clk);
    resp2 = 1'b1; rdata2 = 16'h1234;
    @(negedge clk);
    resp2 = 1'b0; full2 = 1'b1;
    #1;
    checkOutput("pre-reset load", 16'(load2), 16'h0001);
    #2;
    reset2 = 1'b1;
    #1;
    checkOutput("async reset load", 16'(load2), 16'h0000);
    checkOutput("async reset read", 16'(read2), 16'h0000);
    checkOutput("async reset addr", addr2, 16'hFFFE);

    // Random traffic against the memory model; the stream model tracks the next PC owed.
    @(negedge clk);
    reset    = 1'b1;
    memAuto  = 1'b1;
    redirect = 1'b0;
    iqFull   = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    expPc  = 16'h0000;
    pushes = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      redirect   = ($urandom_range(0, 19) == 0);
      redirectPc = 16'($urandom);
      iqFull     = ($urandom_range(0, 2) == 0);
      #1;
      capture = imemRead && !memBusy && !memResp;
      accept  = iqLoad && !iqFull;
      if (imemRead && (memBusy || memResp))
        checkOutput("rand addr stable", imemAddress, memAddr);
      if (capture)
        checkOutput("rand fetch addr", imemAddress, expPc);
      if (accept) begin
        checkOutput("rand push pc", iqPc, expPc);
        checkOutput("rand push instr", iqInstr, instrOf(expPc));
        expPc  = expPc + 16'd2;
        pushes++;
      end
      if (redirect)
        expPc = redirectPc & 16'hFFFE;
    end
    checks++;
    if (pushes < 50) begin
      errors++;
      $display("[TB] FAIL rand progress actual=%0d pushes required>=50", pushes);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
